// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared widths, WB source codes, handshake FSM states and the EX/MEM bundle
//   WORD_SIZE   datapath width
//   MEM_TIMEOUT BUSY cycles without d_ack before the handshake gives up
package mem_stage_pkg;
    localparam int WORD_SIZE   = 16;
    localparam int MEM_TIMEOUT = 255;

    localparam logic [1:0] RWSRC_ALU = 2'b00;
    localparam logic [1:0] RWSRC_MEM = 2'b01;
    localparam logic [1:0] RWSRC_PC  = 2'b10;

    typedef enum logic [1:0] {
        MEM_FSM_IDLE  = 2'd0,
        MEM_FSM_BUSY  = 2'd1,
        MEM_FSM_ERROR = 2'd2
    } mem_fsm_t;

    typedef struct packed {
        logic [WORD_SIZE-1:0] pc;
        logic [WORD_SIZE-1:0] aluout;
        logic [WORD_SIZE-1:0] storedata;
        logic [1:0]           rwtarget;
        logic                 memread;
        logic                 memwrite;
        logic [1:0]           rwsrc;
        logic                 regwrite;
    } em_t;
endpackage

// File: rtl/mem_stage_if.sv
// mem_stage_if: data-memory req/ack bus
//   d_readM/d_writeM  request strobes (stage -> memory)
//   d_address/d_wdata address and store data (stage -> memory)
//   d_rdata/d_ack     load data and completion (memory -> stage)
interface mem_stage_if;
    import mem_stage_pkg::*;
    logic                 d_readM;
    logic                 d_writeM;
    logic [WORD_SIZE-1:0] d_address;
    logic [WORD_SIZE-1:0] d_wdata;
    logic [WORD_SIZE-1:0] d_rdata;
    logic                 d_ack;
    modport master (output d_readM, d_writeM, d_address, d_wdata, input d_rdata, d_ack);
    modport slave  (input d_readM, d_writeM, d_address, d_wdata, output d_rdata, d_ack);
endinterface

// File: rtl/mem_stage_fsm.sv
// mem_handshake_fsm: req/ack sequencing with saturating timeout counter
//   clk, reset_n  clock and async active-high reset
//   pending       EX/MEM holds a valid memory access
//   ack           memory completion this cycle
//   req           drive the memory request strobe
//   stall         hold upstream stages
//   mem_error     sticky timeout flag
module mem_handshake_fsm
    import mem_stage_pkg::*;
#(
    parameter int TIMEOUT = MEM_TIMEOUT
) (
    input  logic clk,
    input  logic reset_n,
    input  logic pending,
    input  logic ack,
    output logic req,
    output logic stall,
    output logic mem_error
);
    mem_fsm_t   state, state_n;
    logic [7:0] cnt;

    always_ff @(posedge clk or posedge reset_n)
        if (reset_n) begin
            state <= MEM_FSM_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= (state != MEM_FSM_BUSY) ? '0 : (&cnt) ? cnt : cnt + 8'd1;
        end

    // ERROR drops the request but keeps the pipeline frozen until reset
    always_comb begin
        state_n   = state;
        mem_error = state == MEM_FSM_ERROR;
        req       = pending & ~mem_error;
        stall     = (req & ~ack) | mem_error;
        case (state)
            MEM_FSM_IDLE: state_n = (req & ~ack) ? MEM_FSM_BUSY : MEM_FSM_IDLE;
            MEM_FSM_BUSY: state_n = ack ? MEM_FSM_IDLE :
                                    (cnt == 8'(TIMEOUT - 1)) ? MEM_FSM_ERROR : MEM_FSM_BUSY;
            default:      state_n = state;
        endcase
    end
endmodule

// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage with EX/MEM and MEM/WB registers and a req/ack data-memory port
//   clk, reset_n      clock and async active-high reset
//   ex_*, flush_i     EX result bundle and squash request
//   stall_o           hold PC/IF/ID/EX while an access is outstanding
//   dmem              data-memory bus (master side)
//   wb_*              registered MEM/WB bundle
//   fwd_*             EX/MEM forwarding taps
//   mem_error_o       sticky memory timeout flag
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 ex_valid_i,
    input  logic [WORD_SIZE-1:0] ex_pc_i,
    input  logic [WORD_SIZE-1:0] ex_aluout_i,
    input  logic [WORD_SIZE-1:0] ex_storedata_i,
    input  logic [1:0]           ex_rwtarget_i,
    input  logic                 ex_memread_i,
    input  logic                 ex_memwrite_i,
    input  logic [1:0]           ex_rwsrc_i,
    input  logic                 ex_regwrite_i,
    input  logic                 flush_i,
    output logic                 stall_o,
    mem_stage_if.master          dmem,
    output logic [WORD_SIZE-1:0] wb_pc_o,
    output logic [WORD_SIZE-1:0] wb_aluout_o,
    output logic [WORD_SIZE-1:0] wb_memdata_o,
    output logic [1:0]           wb_rwtarget_o,
    output logic [1:0]           wb_rwsrc_o,
    output logic                 wb_regwrite_o,
    output logic                 wb_valid_o,
    output logic                 fwd_regwrite_o,
    output logic [1:0]           fwd_target_o,
    output logic [WORD_SIZE-1:0] fwd_data_o,
    output logic                 mem_error_o
);
    em_t  em;
    logic em_valid, req, is_load;

    // a simultaneous read+write is treated as a store
    assign is_load = em.memread & ~em.memwrite;

    mem_handshake_fsm u_fsm (
        .clk       (clk),
        .reset_n   (reset_n),
        .pending   (em_valid & (em.memread | em.memwrite)),
        .ack       (dmem.d_ack),
        .req       (req),
        .stall     (stall_o),
        .mem_error (mem_error_o)
    );

    assign dmem.d_writeM  = req & em.memwrite;
    assign dmem.d_readM   = req & is_load;
    assign dmem.d_address = em.aluout;
    assign dmem.d_wdata   = em.storedata;

    assign fwd_regwrite_o = em_valid & em.regwrite;
    assign fwd_target_o   = em.rwtarget;
    assign fwd_data_o     = em.aluout;

    // flush only acts on capture, so it is implicitly ignored while stalled
    always_ff @(posedge clk or posedge reset_n)
        if (reset_n) begin
            em       <= '0;
            em_valid <= 1'b0;
        end else if (!stall_o) begin
            em       <= '{pc: ex_pc_i, aluout: ex_aluout_i, storedata: ex_storedata_i,
                          rwtarget: ex_rwtarget_i, memread: ex_memread_i, memwrite: ex_memwrite_i,
                          rwsrc: ex_rwsrc_i, regwrite: ex_regwrite_i};
            em_valid <= ex_valid_i & ~flush_i;
        end

    // memdata keeps its last loaded value across non-load instructions and bubbles
    always_ff @(posedge clk or posedge reset_n)
        if (reset_n) begin
            wb_pc_o       <= '0;
            wb_aluout_o   <= '0;
            wb_memdata_o  <= '0;
            wb_rwtarget_o <= '0;
            wb_rwsrc_o    <= '0;
            wb_regwrite_o <= 1'b0;
            wb_valid_o    <= 1'b0;
        end else if (em_valid && !stall_o) begin
            wb_pc_o       <= em.pc;
            wb_aluout_o   <= em.aluout;
            wb_rwtarget_o <= em.rwtarget;
            wb_rwsrc_o    <= em.rwsrc;
            wb_regwrite_o <= em.regwrite;
            wb_valid_o    <= 1'b1;
            if (is_load && dmem.d_ack) wb_memdata_o <= dmem.d_rdata;
        end else begin
            wb_regwrite_o <= 1'b0;
            wb_valid_o    <= 1'b0;
        end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: vector table, hand sequences and randomized model check of mem_stage
module tb_mem_stage;
    import mem_stage_pkg::*;

    typedef struct {
        logic        valid, flush, rd, wr, rw;
        logic [1:0]  tgt, src;
        logic [15:0] pc, alu, sd;
    } ins_t;

    typedef struct {
        ins_t        i;
        logic        ack;
        logic [15:0] rdata;
        logic        e_stall, e_rdm, e_wrm, e_wbv, e_wbrw;
        logic [15:0] e_mem;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ex_valid_i, ex_memread_i, ex_memwrite_i, ex_regwrite_i, flush_i;
    logic [15:0] ex_pc_i, ex_aluout_i, ex_storedata_i;
    logic [1:0]  ex_rwtarget_i, ex_rwsrc_i;
    logic        stall_o, wb_regwrite_o, wb_valid_o, fwd_regwrite_o, mem_error_o;
    logic [15:0] wb_pc_o, wb_aluout_o, wb_memdata_o, fwd_data_o;
    logic [1:0]  wb_rwtarget_o, wb_rwsrc_o, fwd_target_o;

    int vectors = 0;
    int miscompares = 0;

    mem_stage_if dmem ();

    mem_stage dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .ex_valid_i     (ex_valid_i),
        .ex_pc_i        (ex_pc_i),
        .ex_aluout_i    (ex_aluout_i),
        .ex_storedata_i (ex_storedata_i),
        .ex_rwtarget_i  (ex_rwtarget_i),
        .ex_memread_i   (ex_memread_i),
        .ex_memwrite_i  (ex_memwrite_i),
        .ex_rwsrc_i     (ex_rwsrc_i),
        .ex_regwrite_i  (ex_regwrite_i),
        .flush_i        (flush_i),
        .stall_o        (stall_o),
        .dmem           (dmem),
        .wb_pc_o        (wb_pc_o),
        .wb_aluout_o    (wb_aluout_o),
        .wb_memdata_o   (wb_memdata_o),
        .wb_rwtarget_o  (wb_rwtarget_o),
        .wb_rwsrc_o     (wb_rwsrc_o),
        .wb_regwrite_o  (wb_regwrite_o),
        .wb_valid_o     (wb_valid_o),
        .fwd_regwrite_o (fwd_regwrite_o),
        .fwd_target_o   (fwd_target_o),
        .fwd_data_o     (fwd_data_o),
        .mem_error_o    (mem_error_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        vectors++;
        if (a !== e) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input ins_t i);
        ex_valid_i     = i.valid;
        flush_i        = i.flush;
        ex_memread_i   = i.rd;
        ex_memwrite_i  = i.wr;
        ex_regwrite_i  = i.rw;
        ex_rwtarget_i  = i.tgt;
        ex_rwsrc_i     = i.src;
        ex_pc_i        = i.pc;
        ex_aluout_i    = i.alu;
        ex_storedata_i = i.sd;
    endtask

    function automatic ins_t mk(input logic v, f, rd, wr, rw, input logic [1:0] tgt, src,
                                input logic [15:0] pc, alu, sd);
        ins_t r;
        r.valid = v; r.flush = f; r.rd = rd; r.wr = wr; r.rw = rw;
        r.tgt = tgt; r.src = src; r.pc = pc; r.alu = alu; r.sd = sd;
        return r;
    endfunction

    function automatic ins_t rnd_ins();
        return mk($urandom_range(0, 9) != 0, $urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 3) == 0, 1'($urandom), 2'($urandom), 2'($urandom),
                  16'($urandom), 16'($urandom), 16'($urandom));
    endfunction

    task automatic run_vec(input vec_t t, input ins_t idle);
        drive(t.i);
        dmem.d_ack = 1'b0;
        tick();
        drive(idle);
        dmem.d_ack   = t.ack;
        dmem.d_rdata = t.rdata;
        #1;
        chk("stall", stall_o, t.e_stall);
        chk("d_readM", dmem.d_readM, t.e_rdm);
        chk("d_writeM", dmem.d_writeM, t.e_wrm);
        if (t.e_rdm | t.e_wrm) chk("d_address", dmem.d_address, t.i.alu);
        if (t.e_wrm) chk("d_wdata", dmem.d_wdata, t.i.sd);
        chk("fwd_regwrite", fwd_regwrite_o, t.i.valid & ~t.i.flush & t.i.rw);
        tick();
        dmem.d_ack = 1'b0;
        #1;
        chk("wb_valid", wb_valid_o, t.e_wbv);
        chk("wb_regwrite", wb_regwrite_o, t.e_wbrw);
        chk("wb_memdata", wb_memdata_o, t.e_mem);
        if (t.e_wbv) begin
            chk("wb_pc", wb_pc_o, t.i.pc);
            chk("wb_aluout", wb_aluout_o, t.i.alu);
            chk("wb_rwtarget", wb_rwtarget_o, t.i.tgt);
            chk("wb_rwsrc", wb_rwsrc_o, t.i.src);
        end
    endtask

    vec_t        tbl[8];
    ins_t        idle, nx, slot, ewb, ld, alu_op;
    logic        slot_v, smem, ack, estall, ewbv, ewbrw;
    logic [15:0] rdata, prevmem, memarr[16];
    int          w, d;

    initial begin
        idle = mk(0, 0, 0, 0, 0, 2'd0, 2'd0, 16'h0, 16'h0, 16'h0);
        tbl[0] = '{mk(1, 0, 0, 0, 1, 2'd2, 2'd0, 16'h0100, 16'h1234, 16'h0000), 1'b0, 16'h0000,
                   1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000};
        tbl[1] = '{mk(1, 0, 0, 1, 0, 2'd0, 2'd0, 16'h0102, 16'h0010, 16'h00AA), 1'b1, 16'h0000,
                   1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000};
        tbl[2] = '{mk(1, 0, 1, 0, 1, 2'd1, 2'd1, 16'h0104, 16'h0040, 16'h0000), 1'b1, 16'hBEEF,
                   1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'hBEEF};
        tbl[3] = '{mk(1, 1, 0, 0, 1, 2'd3, 2'd0, 16'h0106, 16'h5555, 16'h0000), 1'b0, 16'h0000,
                   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'hBEEF};
        tbl[4] = '{mk(0, 0, 1, 0, 1, 2'd1, 2'd1, 16'h0108, 16'h0044, 16'h0000), 1'b1, 16'h1357,
                   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'hBEEF};
        tbl[5] = '{mk(1, 0, 1, 1, 0, 2'd2, 2'd1, 16'h010A, 16'h0048, 16'h7777), 1'b1, 16'h1111,
                   1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'hBEEF};
        tbl[6] = '{mk(1, 0, 0, 0, 1, 2'd3, 2'd2, 16'h0222, 16'hFFFF, 16'h0000), 1'b0, 16'h0000,
                   1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'hBEEF};
        tbl[7] = '{mk(1, 0, 1, 0, 1, 2'd2, 2'd1, 16'h010E, 16'h004C, 16'h0000), 1'b1, 16'h5A5A,
                   1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h5A5A};

        drive(idle);
        dmem.d_ack   = 1'b0;
        dmem.d_rdata = 16'h0;
        reset_n      = 1'b1;
        #3;
        chk("rst stall", stall_o, 0);
        chk("rst d_readM", dmem.d_readM, 0);
        chk("rst d_writeM", dmem.d_writeM, 0);
        chk("rst wb_valid", wb_valid_o, 0);
        chk("rst mem_error", mem_error_o, 0);
        chk("rst wb_memdata", wb_memdata_o, 0);
        tick();
        reset_n = 1'b0;

        for (int i = 0; i < 8; i++) run_vec(tbl[i], idle);

        // load acked on its fourth request cycle; a flushed op waits behind it
        ld     = mk(1, 0, 1, 0, 1, 2'd1, 2'd1, 16'h0200, 16'h0040, 16'h0000);
        alu_op = mk(1, 1, 0, 0, 1, 2'd2, 2'd0, 16'h0202, 16'h0777, 16'h0000);
        drive(ld);
        tick();
        for (int c = 0; c < 4; c++) begin
            alu_op.flush = c < 3;
            drive(alu_op);
            dmem.d_ack   = c == 3;
            dmem.d_rdata = (c == 3) ? 16'hBEEF : 16'h0000;
            #1;
            chk("load stall", stall_o, c < 3);
            chk("load d_readM", dmem.d_readM, 1);
            chk("load bubble", wb_valid_o, 0);
            tick();
        end
        drive(idle);
        dmem.d_ack = 1'b0;
        #1;
        chk("load wb_valid", wb_valid_o, 1);
        chk("load wb_memdata", wb_memdata_o, 16'hBEEF);
        chk("load wb_pc", wb_pc_o, 16'h0200);
        chk("post-load stall", stall_o, 0);
        tick();
        chk("held op wb_valid", wb_valid_o, 1);
        chk("held op wb_aluout", wb_aluout_o, 16'h0777);

        // randomized traffic against an in-order slot model with random memory latency
        reset_n = 1'b1;
        tick();
        reset_n = 1'b0;
        for (int i = 0; i < 16; i++) memarr[i] = 16'($urandom);
        slot_v = 1'b0; slot = idle; ewb = idle; ewbv = 1'b0; ewbrw = 1'b0; prevmem = 16'h0;
        w = 0; d = 0;
        nx = rnd_ins();
        for (int cyc = 0; cyc < 600; cyc++) begin
            smem  = slot_v & (slot.rd | slot.wr);
            ack   = smem & (w == d);
            rdata = (smem & slot.rd & ~slot.wr & ack) ? memarr[slot.alu[3:0]] : 16'($urandom);
            dmem.d_ack   = ack;
            dmem.d_rdata = rdata;
            drive(nx);
            #1;
            estall = smem & ~ack;
            chk("rnd stall", stall_o, estall);
            chk("rnd d_readM", dmem.d_readM, smem & slot.rd & ~slot.wr);
            chk("rnd d_writeM", dmem.d_writeM, smem & slot.wr);
            if (smem) chk("rnd d_address", dmem.d_address, slot.alu);
            if (smem & slot.wr) chk("rnd d_wdata", dmem.d_wdata, slot.sd);
            chk("rnd fwd_regwrite", fwd_regwrite_o, slot_v & slot.rw);
            if (slot_v) chk("rnd fwd_data", fwd_data_o, slot.alu);
            chk("rnd wb_valid", wb_valid_o, ewbv);
            chk("rnd wb_regwrite", wb_regwrite_o, ewbrw);
            if (ewbv) begin
                chk("rnd wb_pc", wb_pc_o, ewb.pc);
                chk("rnd wb_aluout", wb_aluout_o, ewb.alu);
                chk("rnd wb_memdata", wb_memdata_o, prevmem);
                chk("rnd wb_rwtarget", wb_rwtarget_o, ewb.tgt);
                chk("rnd wb_rwsrc", wb_rwsrc_o, ewb.src);
            end
            if (!estall) begin
                ewbv  = slot_v;
                ewbrw = slot_v & slot.rw;
                if (slot_v) begin
                    ewb = slot;
                    if (slot.rd & ~slot.wr) prevmem = rdata;
                    if (slot.wr) memarr[slot.alu[3:0]] = slot.sd;
                end
                slot_v = nx.valid & ~nx.flush;
                slot   = nx;
                w      = 0;
                d      = $urandom_range(0, 4);
                nx     = rnd_ins();
            end else begin
                w++;
                ewbv  = 1'b0;
                ewbrw = 1'b0;
            end
            tick();
        end

        // reset while BUSY, then a late ack
        drive(ld);
        dmem.d_ack = 1'b0;
        tick();
        drive(idle);
        tick();
        tick();
        reset_n = 1'b1;
        #1;
        chk("midrst d_readM", dmem.d_readM, 0);
        chk("midrst stall", stall_o, 0);
        chk("midrst wb_valid", wb_valid_o, 0);
        chk("midrst fwd_regwrite", fwd_regwrite_o, 0);
        tick();
        reset_n    = 1'b0;
        dmem.d_ack = 1'b1;
        #1;
        chk("late ack stall", stall_o, 0);
        tick();
        dmem.d_ack = 1'b0;
        chk("late ack wb_valid", wb_valid_o, 0);
        run_vec(tbl[0], idle);

        // load never acked: 255 BUSY cycles then terminal ERROR
        drive(ld);
        tick();
        drive(idle);
        for (int c = 0; c < 260; c++) begin
            dmem.d_ack = c > 256;
            #1;
            chk("timeout stall", stall_o, 1);
            if (c == 0 || c == 255 || c >= 256) begin
                chk("timeout mem_error", mem_error_o, c >= 256);
                chk("timeout d_readM", dmem.d_readM, c < 256);
            end
            tick();
        end
        dmem.d_ack = 1'b0;
        reset_n    = 1'b1;
        tick();
        reset_n = 1'b0;
        chk("err cleared", mem_error_o, 0);
        run_vec(tbl[0], idle);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
